// File: rtl/rng_pkg.sv
// Shared definitions for the range-limited LFSR random source: tap masks,
// draw FSM states and the range-to-mask helper.
package rng_pkg;

  // Maximal-length Fibonacci tap masks, indexed by LFSR width.
  localparam logic [31:0] TAPS [3:32] = '{
    32'h0000_0006, 32'h0000_000C, 32'h0000_0014, 32'h0000_0030,
    32'h0000_0060, 32'h0000_00B8, 32'h0000_0110, 32'h0000_0240,
    32'h0000_0500, 32'h0000_0829, 32'h0000_100D, 32'h0000_2015,
    32'h0000_6000, 32'h0000_B400, 32'h0001_2000, 32'h0002_0400,
    32'h0004_0023, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000,
    32'h0042_0000, 32'h00E1_0000, 32'h0120_0000, 32'h0200_0023,
    32'h0400_0013, 32'h0900_0000, 32'h1400_0000, 32'h2000_0029,
    32'h4800_0000, 32'h8020_0003
  };

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } fsm_t;

  // Smallest 2^k-1 that covers range_max (0 for range_max == 0).
  function automatic logic [31:0] range_mask(input logic [31:0] range_max);
    logic [31:0] m;
    m = range_max;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed load, all-zero recovery and
// conditional advance.
module lfsr_core
  import rng_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] SEED_INIT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH][WIDTH-1:0];

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;
  logic             fb;

  assign fb = ^(state_reg & TAP_MASK);

  // Seed load wins over everything; a zero state can never feed the shifter.
  always_comb begin
    state_next = state_reg;
    if (seed_load) begin
      state_next = (seed == '0) ? WIDTH'(1) : seed;
    end else if (state_reg == '0) begin
      state_next = WIDTH'(1);
    end else if (advance) begin
      state_next = {state_reg[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SEED_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/lfsr_rng.sv
// Bounded on-demand random draws from an LFSR. Define RNG_REJECT_EN for
// rejection sampling; otherwise out-of-range candidates are folded back.
module lfsr_rng
  import rng_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               OUT_W     = 4,
  parameter logic [WIDTH-1:0] SEED_INIT = WIDTH'(1),
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [OUT_W-1:0] range_max,
  output logic [OUT_W-1:0] rnd,
  output logic             rnd_valid,
  output logic             busy,
  output logic [WIDTH-1:0] state_o
);

  if (WIDTH < 3 || WIDTH > 32 || OUT_W > WIDTH || MAX_TRIES < 1 || SEED_INIT == '0) begin : g_bad_params
    $error("lfsr_rng: illegal parameter combination");
  end

  fsm_t             fsm_reg, fsm_next;
  logic [OUT_W-1:0] range_reg, range_next;
  logic [OUT_W-1:0] mask_reg, mask_next;
  logic [OUT_W-1:0] rnd_reg, rnd_next;
  logic             valid_reg, valid_next;
  logic [WIDTH-1:0] lfsr_state;
  logic [OUT_W-1:0] cand;

`ifdef RNG_REJECT_EN
  localparam int TW = $clog2(MAX_TRIES + 1);
  logic [TW-1:0] tries_reg, tries_next;
`endif

  lfsr_core #(
    .WIDTH     (WIDTH),
    .SEED_INIT (SEED_INIT)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .advance   ((fsm_reg == DRAW) || en),
    .state     (lfsr_state)
  );

  assign cand = lfsr_state[OUT_W-1:0] & mask_reg;

  always_comb begin
    fsm_next   = fsm_reg;
    range_next = range_reg;
    mask_next  = mask_reg;
    rnd_next   = rnd_reg;
    valid_next = 1'b0;
`ifdef RNG_REJECT_EN
    tries_next = tries_reg;
`endif
    case (fsm_reg)
      IDLE: begin
        if (req) begin
          range_next = range_max;
          mask_next  = OUT_W'(range_mask(32'(range_max)));
          fsm_next   = DRAW;
`ifdef RNG_REJECT_EN
          tries_next = '0;
`endif
        end
      end
      DRAW: begin
`ifdef RNG_REJECT_EN
        if (cand <= range_reg) begin
          rnd_next   = cand;
          valid_next = 1'b1;
          fsm_next   = IDLE;
        end else if (tries_reg + TW'(1) == TW'(MAX_TRIES)) begin
          // Halving a masked candidate always lands within range.
          rnd_next   = cand >> 1;
          valid_next = 1'b1;
          fsm_next   = IDLE;
        end else begin
          tries_next = tries_reg + TW'(1);
        end
`else
        // mask <= 2*range+1, so the folded value never exceeds range.
        rnd_next   = (cand <= range_reg) ? cand : cand - range_reg - OUT_W'(1);
        valid_next = 1'b1;
        fsm_next   = IDLE;
`endif
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg   <= IDLE;
      range_reg <= '0;
      mask_reg  <= '0;
      rnd_reg   <= '0;
      valid_reg <= 1'b0;
`ifdef RNG_REJECT_EN
      tries_reg <= '0;
`endif
    end else begin
      fsm_reg   <= fsm_next;
      range_reg <= range_next;
      mask_reg  <= mask_next;
      rnd_reg   <= rnd_next;
      valid_reg <= valid_next;
`ifdef RNG_REJECT_EN
      tries_reg <= tries_next;
`endif
    end
  end

  assign rnd       = rnd_reg;
  assign rnd_valid = valid_reg;
  assign busy      = (fsm_reg == DRAW);
  assign state_o   = lfsr_state;

endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised pseudo-random source for the game logic: a maximal-length Fibonacci LFSR of configurable width with seed loading and on-demand range-limited draws. A client pulses `req` with an upper bound; the block returns one value in `[0, range_max]` with a `rnd_valid` pulse. It replaces fixed-width free-running generators where serve direction, ball angle or AI jitter need a bounded value.

## Interface
- `WIDTH`, 16: LFSR width, legal range 3..32.
- `OUT_W`, 4: result width; `OUT_W <= WIDTH`.
- `SEED_INIT`, 1: state after reset; must be nonzero.
- `MAX_TRIES`, 8: rejection limit per draw, at least 1.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  advance the LFSR while idle.
- `seed_load`  in  1  load `seed` into the state this cycle.
- `seed`  in  WIDTH  seed value; zero is replaced by 1.
- `req`  in  1  draw request, sampled in IDLE only.
- `range_max`  in  OUT_W  inclusive upper bound, sampled on accept.
- `rnd`  out  OUT_W  result, held until the next result.
- `rnd_valid`  out  1  one-cycle pulse, `rnd` is new.
- `busy`  out  1  high while in DRAW.
- `state_o`  out  WIDTH  raw LFSR state, for debug.

## Operation
- Feedback: `fb = ^(state & TAPS[WIDTH])`. Next state is `{state[WIDTH-2:0], fb}`.
- LFSR update priority:
  - `seed_load` first; a `seed` of 0 loads 1.
  - Otherwise advance if FSM is in DRAW or `en=1`.
  - Otherwise hold.
- All-zero state is unreachable. If it is ever detected, the next state is forced to 1.
- `mask`: the smallest `2^k-1` that is `>= range_max` (0 when `range_max=0`).
- `cand = state[OUT_W-1:0] & mask`.
- FSM IDLE:
  - `req=1` latches `range_max` and `mask`, clears the try counter, and moves to DRAW.
  - `req` is ignored outside IDLE.
- FSM DRAW, evaluated once per cycle on the current state (the state advances the same cycle):
  - If `cand <= range_max`: `rnd <= cand`, pulse `rnd_valid` next cycle, go to IDLE.
  - Else increment tries. When tries reaches `MAX_TRIES`: `rnd <= cand >> 1`, valid, go to IDLE. `cand >> 1` is always within range.
  - Else stay in DRAW.
- `seed_load` during DRAW: the new state is used from the next cycle; the draw continues.
- Reset values: `rnd=0`, `rnd_valid=0`, `busy=0`, FSM=IDLE, `state=SEED_INIT`, counters 0.
- `rst` in mid-draw aborts the draw; no `rnd_valid` is produced.

## Timing
- Cycle 0: `req` is sampled in IDLE.
- Cycle 1: DRAW, `busy=1`, first evaluation.
- Cycle 2: `rnd_valid=1` if the first evaluation accepted. Minimum latency is 2.
- Maximum latency is `MAX_TRIES+1`. Each rejection adds 1 cycle.
- `req` may be reasserted in the same cycle `rnd_valid` is high; it is accepted, giving back-to-back draws every 2 cycles at best.
- `state_o` is registered and shows the current state.
- Period is `2^WIDTH-1` for every legal `WIDTH`.

## Configuration
- `RNG_REJECT_EN` defined: rejection sampling as described; result distribution is uniform apart from the fallback.
- `RNG_REJECT_EN` undefined:
  - DRAW always lasts exactly one cycle, so latency is fixed at 2.
  - `rnd = (cand <= range_max) ? cand : cand - (range_max+1)`. This result is biased but always in range.
  - `MAX_TRIES` and the try counter are unused.

## Structure
- Package `rng_pkg` contains:
  - `TAPS[3:32]`: maximal-length tap masks (e.g. 3:'h6, 4:'hC, 5:'h14, 8:'hB8, 16:'hB400, 32:'h80200003).
  - FSM state enum `{IDLE, DRAW}`.
  - Function `range_mask(range_max)`.
- One sub-module, `lfsr_core`: owns the state register, seed load, zero guard and advance. `lfsr_rng` holds the FSM and the range logic.

## Test plan
All scenarios use `WIDTH=3`, `OUT_W=3`, `en=0` and seed 1 unless stated. The expected sequence from seed 1 is 1,2,5,3,7,6,4,1.
- Period: reset with `SEED_INIT=1` and `en=1` for 8 cycles -> `state_o` shows 1,2,5,3,7,6,4,1.
- Zero seed: `seed_load=1` with `seed=0` -> `state_o=1` next cycle; the state is never 0 afterwards.
- Reject path, `range_max=4`:
  - req -> `rnd=1` at cycle 2.
  - req -> `rnd=2`.
  - req -> state 5 rejected, state 3 accepted -> `rnd=3` at cycle 3.
- Fallback: `MAX_TRIES=1`, state 5, `range_max=4`, req -> `rnd=2` at cycle 2.
- Macro off: state 5, `range_max=4` -> `rnd=0` at cycle 2. `range_max=0` with any state -> `rnd=0`.
- Reset mid-draw: `rst` during DRAW -> no `rnd_valid`; `busy=0` and `state_o=SEED_INIT` the next cycle.
